// File: rtl/deser8way_pkg.sv
// deser8way_pkg: typed view of the shared deser8way constants.
// Frame length follows DESER8WAY_PARITY_EN (9 bits with parity, 8 without).
`include "deser8way_defs.v"

package deser8way_pkg;

    localparam int unsigned DataW  = `DESER8WAY_W;
    localparam int unsigned CntW   = `DESER8WAY_CNT_W;
    localparam int unsigned FrameN = `DESER8WAY_N;

    typedef logic [CntW-1:0]  cnt_t;
    typedef logic [DataW-1:0] word_t;

    localparam cnt_t LastSlot = cnt_t'(FrameN - 1);

    // Odd parity: the frame is bad when data plus parity bit XOR to zero.
    function automatic logic parity_bad(input word_t data, input logic pbit);
        return ~(^data ^ pbit);
    endfunction

endpackage

// File: rtl/deser8way_defs.v
// deser8way shared constants.
// Optional build macro DESER8WAY_PARITY_EN adds a trailing odd-parity bit to each frame.
`ifndef DESER8WAY_DEFS_V
`define DESER8WAY_DEFS_V

`define DESER8WAY_W     8
`define DESER8WAY_CNT_W 4

`ifdef DESER8WAY_PARITY_EN
`define DESER8WAY_N 9
`else
`define DESER8WAY_N 8
`endif

`endif

// File: rtl/dmux8way.sv
// dmux8way: 1-to-8 demultiplexer producing one-hot write enables.
// Ports:
//   en_i   - enable; all outputs low when 0
//   sel_i  - selected output index
//   out_o  - one-hot enables (bit sel_i high when en_i)
module dmux8way (
    input  logic       en_i,
    input  logic [2:0] sel_i,
    output logic [7:0] out_o
);

    always_comb begin
        out_o = 8'h00;
        if (en_i) begin
            out_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/deser8way.sv
// deser8way: serial-to-parallel deserializer, LSB first, double-buffered 8-bit output.
// Build macro: DESER8WAY_PARITY_EN adds a 9th odd-parity bit per frame and parity_err_o.
// Ports:
//   clk_i, rst_i              - clock, asynchronous active-high reset
//   in_i, in_valid_i          - serial bit and its valid
//   in_ready_o                - bit can be accepted this cycle
//   out_o, out_valid_o        - completed word and its valid
//   out_ready_i               - consumer takes out_o this cycle
//   out_any_o                 - OR of all bits of the word in out_o
//   parity_err_o              - (parity build only) word failed odd parity
module deser8way
    import deser8way_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic [7:0] out_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
`ifdef DESER8WAY_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       out_any_o
);

    cnt_t  cnt_q, cnt_d;
    word_t col_q, col_d;
    word_t out_q, out_d;
    logic  out_valid_q, out_valid_d;
    logic  out_any_q, out_any_d;
    logic  word_any;
    logic  last_slot, accept, complete;
    logic [7:0] slot_en;

    assign last_slot  = (cnt_q == LastSlot);
    // Only the completing bit stalls; earlier bits land in col while out is held.
    assign in_ready_o = !(last_slot && out_valid_q && !out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign complete   = accept && last_slot;

    // Parity slot (cnt 8) has no column; the decoder is disabled there.
    dmux8way u_dmux (
        .en_i  (accept && (cnt_q < cnt_t'(DataW))),
        .sel_i (cnt_q[2:0]),
        .out_o (slot_en)
    );

    always_comb begin
        col_d = col_q;
        for (int k = 0; k < 8; k++) begin
            if (slot_en[k]) begin
                col_d[k] = in_i;
            end
        end
    end

    // col_d already holds the final data bit on the completing edge of an 8-bit frame.
    or u_any_or (word_any, col_d[0], col_d[1], col_d[2], col_d[3],
                 col_d[4], col_d[5], col_d[6], col_d[7]);

    always_comb begin
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_any_d   = out_any_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            cnt_d = last_slot ? cnt_t'(0) : cnt_q + cnt_t'(1);
        end
        if (complete) begin
            out_d       = col_d;
            out_any_d   = word_any;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            col_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_any_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_any_q   <= out_any_d;
        end
    end

`ifdef DESER8WAY_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = parity_err_q;
        if (complete) begin
            parity_err_d = parity_bad(col_q, in_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign out_any_o   = out_any_q;

endmodule

// File: tb/tb_deser8way.sv
// tb_deser8way: directed self-checking bench for deser8way (either build of DESER8WAY_PARITY_EN).
module tb_deser8way;

`ifdef DESER8WAY_PARITY_EN
    localparam int N = 9;
`else
    localparam int N = 8;
`endif

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_bit    = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_any;
    logic [7:0] out_word;
`ifdef DESER8WAY_PARITY_EN
    logic       parity_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    deser8way dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_i         (in_bit),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .out_o        (out_word),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
`ifdef DESER8WAY_PARITY_EN
        .parity_err_o (parity_err),
`endif
        .out_any_o    (out_any)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic odd_p(input logic [7:0] w);
        return ~(^w);
    endfunction

    function automatic logic frame_bit(input logic [7:0] w, input int i, input logic p);
        if (i < 8) return w[i];
        return p;
    endfunction

    // Present one bit, wait (bounded) for in_ready, let one edge take it.
    task automatic send_bit(input logic b);
        int waited = 0;
        in_bit   = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (waited >= 50) begin
            n_assert++;
            n_fail++;
            $error("FAIL send_bit: in_ready stayed 0 for %0d cycles, required 1", waited);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input logic p, input int count);
        for (int i = 0; i < count; i++) begin
            send_bit(frame_bit(w, i, p));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_out", out_word, 8'h00);
        chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_out_any", {7'd0, out_any}, 8'h00);
        chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
        @(negedge clk);
        rst = 1'b0;

        // Hold a word, start another frame, then reset asynchronously between edges
        out_ready = 1'b0;
        send_bits(8'hFF, odd_p(8'hFF), N);
        chk("held_ff_out", out_word, 8'hFF);
        chk("held_ff_valid", {7'd0, out_valid}, 8'h01);
        send_bits(8'h12, odd_p(8'h12), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out", out_word, 8'h00);
        chk("async_rst_valid", {7'd0, out_valid}, 8'h00);
        chk("async_rst_any", {7'd0, out_any}, 8'h00);
`ifdef DESER8WAY_PARITY_EN
        chk("async_rst_perr", {7'd0, parity_err}, 8'h00);
`endif
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send_bits(8'h3C, odd_p(8'h3C), N);
        chk("post_rst_3c_out", out_word, 8'h3C);
        chk("post_rst_3c_valid", {7'd0, out_valid}, 8'h01);

        // Basic frame 0xA5, zero latency on the final bit, valid for one cycle
        send_bits(8'hA5, odd_p(8'hA5), N - 1);
        chk("a5_pre_valid", {7'd0, out_valid}, 8'h00);
        chk("a5_pre_out_hold", out_word, 8'h3C);
        send_bit(frame_bit(8'hA5, N - 1, odd_p(8'hA5)));
        chk("a5_out", out_word, 8'hA5);
        chk("a5_valid", {7'd0, out_valid}, 8'h01);
        chk("a5_any", {7'd0, out_any}, 8'h01);
        step();
        chk("a5_valid_drop", {7'd0, out_valid}, 8'h00);

        // Zero word and MSB-only word
        send_bits(8'h00, odd_p(8'h00), N);
        chk("zero_out", out_word, 8'h00);
        chk("zero_any", {7'd0, out_any}, 8'h00);
        send_bits(8'h80, odd_p(8'h80), N);
        chk("msb_out", out_word, 8'h80);
        chk("msb_any", {7'd0, out_any}, 8'h01);
        step();

        // Backpressure: only the completing bit stalls
        out_ready = 1'b0;
        send_bits(8'h0F, odd_p(8'h0F), N);
        chk("bp_0f_out", out_word, 8'h0F);
        send_bits(8'hF0, odd_p(8'hF0), N - 1);
        in_bit   = frame_bit(8'hF0, N - 1, odd_p(8'hF0));
        in_valid = 1'b1;
        #1;
        chk("bp_stall_ready", {7'd0, in_ready}, 8'h00);
        step();
        chk("bp_hold_out", out_word, 8'h0F);
        chk("bp_hold_valid", {7'd0, out_valid}, 8'h01);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {7'd0, in_ready}, 8'h01);
        step();
        in_valid = 1'b0;
        chk("bp_f0_out", out_word, 8'hF0);
        chk("bp_f0_valid", {7'd0, out_valid}, 8'h01);
        step();
        chk("bp_f0_consumed", {7'd0, out_valid}, 8'h00);

        // Consume and complete on the same edge
        out_ready = 1'b0;
        send_bits(8'h7E, odd_p(8'h7E), N);
        chk("sim_7e_out", out_word, 8'h7E);
        send_bits(8'h81, odd_p(8'h81), N - 1);
        chk("sim_7e_still", out_word, 8'h7E);
        out_ready = 1'b1;
        send_bit(frame_bit(8'h81, N - 1, odd_p(8'h81)));
        chk("sim_81_out", out_word, 8'h81);
        chk("sim_81_valid", {7'd0, out_valid}, 8'h01);
        step();
        chk("sim_no_dup", {7'd0, out_valid}, 8'h00);

        // Gaps in in_valid keep frame position
        for (int i = 0; i < N; i++) begin
            send_bit(frame_bit(8'hC3, i, odd_p(8'hC3)));
            for (int g = 0; g < (i % 3); g++) step();
        end
        chk("gap_c3_out", out_word, 8'hC3);
        chk("gap_c3_any", {7'd0, out_any}, 8'h01);

`ifdef DESER8WAY_PARITY_EN
        send_bits(8'hA5, 1'b1, N);
        chk("par_good_perr", {7'd0, parity_err}, 8'h00);
        chk("par_good_out", out_word, 8'hA5);
        send_bits(8'hA5, 1'b0, N);
        chk("par_bad_perr", {7'd0, parity_err}, 8'h01);
        chk("par_bad_out", out_word, 8'hA5);
        chk("par_bad_valid", {7'd0, out_valid}, 8'h01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
